// File: rtl/lamp_pkg.sv
// Shared types and bit positions for the lamp controller.
// Fade states and the led_port / full-colour LED index map.
package lamp_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RISE = 2'd1,
      ON   = 2'd2,
      FALL = 2'd3
   } fade_state_t;

   // led_port bit map
   localparam int unsigned LED_LEFT_HI     = 7;
   localparam int unsigned LED_LEFT_LO     = 6;
   localparam int unsigned LED_TAIL_OUT_HI = 5;
   localparam int unsigned LED_TAIL_IN_HI  = 4;
   localparam int unsigned LED_TAIL_IN_LO  = 3;
   localparam int unsigned LED_TAIL_OUT_LO = 2;
   localparam int unsigned LED_RIGHT_HI    = 1;
   localparam int unsigned LED_RIGHT_LO    = 0;

   // fc_red / fc_green / fc_blue bit map
   localparam int unsigned FC_HIGH_0 = 0;
   localparam int unsigned FC_HIGH_1 = 1;
   localparam int unsigned FC_LOW_0  = 2;
   localparam int unsigned FC_LOW_1  = 3;

endpackage

// File: rtl/lamp_controller_blink_gen.sv
// Indicator blink phase generator shared by both sides.
// Idle forces phase high so a fresh request lights immediately.
module blink_gen #(
   parameter int unsigned BLINK_HALF = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   output logic phase
);

   localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (!active) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lamp_controller.sv
// Vehicle lamp controller: auto-light hysteresis, headlight fade,
// tail/reverse PWM and hazard/turn indicators, all outputs registered.
module lamp_controller
   import lamp_pkg::*;
#(
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned TAIL_DUTY  = 77,
   parameter int unsigned REV_DUTY   = 179,
   parameter int unsigned DARK_ON    = 100,
   parameter int unsigned DARK_OFF   = 130,
   parameter int unsigned DWELL      = 1000,
   parameter int unsigned BLINK_HALF = 25_000_000,
   parameter int unsigned FADE_DIV   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_headlight,
   input  logic             sw_high_beam,
   input  logic             sw_hazard,
   input  logic [7:0]       cds_val,
   input  logic             is_brake,
   input  logic             is_reverse,
   input  logic             turn_left,
   input  logic             turn_right,
   output logic [3:0]       fc_red,
   output logic [3:0]       fc_green,
   output logic [3:0]       fc_blue,
   output logic [7:0]       led_port,
   output logic [PWM_W-1:0] head_level,
   output logic             is_dark
);

   localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FADE_DIV - 1);
   localparam logic [7:0]       DARK_ON_V  = 8'(DARK_ON);
   localparam logic [7:0]       DARK_OFF_V = 8'(DARK_OFF);
   localparam logic [PWM_W:0]   TAIL_D     = (PWM_W + 1)'(TAIL_DUTY);
   localparam logic [PWM_W:0]   REV_D      = (PWM_W + 1)'(REV_DUTY);
   localparam logic [PWM_W-1:0] LVL_MAX    = '1;
   localparam logic [PWM_W-1:0] LVL_ONE    = PWM_W'(1);

   logic [PWM_W-1:0] pwm_cnt;
   logic [DW_W-1:0]  dwell_cnt;
   logic             dark_int;
   logic             dark_qual;
   logic             head_req;

   fade_state_t      state, state_nx;
   logic [PWM_W-1:0] level, level_nx;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic             fade_tick;

   logic             left_act, right_act, phase;
   logic             low_on, high_on, tail_outer, tail_inner;
   logic [PWM_W:0]   pwm_ext;
   logic [3:0]       fc_nx;
   logic [7:0]       led_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pwm_cnt <= '0;
      else      pwm_cnt <= pwm_cnt + LVL_ONE;
   end

   // Only cycles pushing toward the opposite decision count; the band between
   // the thresholds (and any opposing sample) restarts the dwell.
   assign dark_qual = dark_int ? (cds_val > DARK_OFF_V) : (cds_val < DARK_ON_V);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell_cnt <= '0;
         dark_int  <= 1'b0;
      end else if (!dark_qual) begin
         dwell_cnt <= '0;
      end else if (dwell_cnt == DWELL_LAST) begin
         dwell_cnt <= '0;
         dark_int  <= ~dark_int;
      end else begin
         dwell_cnt <= dwell_cnt + DW_W'(1);
      end
   end

   assign head_req  = sw_headlight | dark_int;
   assign fade_tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= OFF;
         level   <= '0;
         div_cnt <= '0;
      end else begin
         state   <= state_nx;
         level   <= level_nx;
         div_cnt <= div_nx;
      end
   end

   // Direction reversals keep the level; the final step and the entry into
   // ON/OFF share one edge so the level never over- or under-runs.
   always_comb begin
      state_nx = state;
      level_nx = level;
      div_nx   = div_cnt;
      case (state)
         OFF: begin
            level_nx = '0;
            if (head_req) begin
               state_nx = RISE;
               div_nx   = '0;
            end
         end
         RISE: begin
            if (!head_req) begin
               state_nx = FALL;
               div_nx   = '0;
            end else if (level == LVL_MAX) begin
               state_nx = ON;
            end else if (fade_tick) begin
               div_nx   = '0;
               level_nx = level + LVL_ONE;
               if (level == LVL_MAX - LVL_ONE) state_nx = ON;
            end else begin
               div_nx = div_cnt + DIV_W'(1);
            end
         end
         ON: begin
            level_nx = LVL_MAX;
            if (!head_req) begin
               state_nx = FALL;
               div_nx   = '0;
            end
         end
         FALL: begin
            if (head_req) begin
               state_nx = RISE;
               div_nx   = '0;
            end else if (level == '0) begin
               state_nx = OFF;
            end else if (fade_tick) begin
               div_nx   = '0;
               level_nx = level - LVL_ONE;
               if (level == LVL_ONE) state_nx = OFF;
            end else begin
               div_nx = div_cnt + DIV_W'(1);
            end
         end
         default: begin
            state_nx = OFF;
            level_nx = '0;
            div_nx   = '0;
         end
      endcase
   end

   assign left_act  = turn_left | sw_hazard;
   assign right_act = turn_right | sw_hazard;

   blink_gen #(
      .BLINK_HALF(BLINK_HALF)
   ) u_blink (
      .clk   (clk),
      .rst   (rst),
      .active(left_act | right_act),
      .phase (phase)
   );

   always_comb begin
      pwm_ext    = {1'b0, pwm_cnt};
      low_on     = (state == ON) | ((state != OFF) & (pwm_ext < {1'b0, level}));
      high_on    = (state == ON) & sw_high_beam;
      tail_outer = is_brake | ((state != OFF) & (pwm_ext < TAIL_D));
      tail_inner = is_reverse ? (pwm_ext < REV_D) : tail_outer;

      fc_nx            = '0;
      fc_nx[FC_HIGH_0] = high_on;
      fc_nx[FC_HIGH_1] = high_on;
      fc_nx[FC_LOW_0]  = low_on;
      fc_nx[FC_LOW_1]  = low_on;

      led_nx                  = '0;
      led_nx[LED_LEFT_HI]     = left_act & phase;
      led_nx[LED_LEFT_LO]     = left_act & phase;
      led_nx[LED_TAIL_OUT_HI] = tail_outer;
      led_nx[LED_TAIL_IN_HI]  = tail_inner;
      led_nx[LED_TAIL_IN_LO]  = tail_inner;
      led_nx[LED_TAIL_OUT_LO] = tail_outer;
      led_nx[LED_RIGHT_HI]    = right_act & phase;
      led_nx[LED_RIGHT_LO]    = right_act & phase;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fc_red     <= '0;
         fc_green   <= '0;
         fc_blue    <= '0;
         led_port   <= '0;
         head_level <= '0;
         is_dark    <= 1'b0;
      end else begin
         fc_red     <= fc_nx;
         fc_green   <= fc_nx;
         fc_blue    <= fc_nx;
         led_port   <= led_nx;
         head_level <= level;
         is_dark    <= dark_int;
      end
   end

endmodule

// File: doc/lamp_controller.md
LAMP_CONTROLLER -- requirements
Module: lamp_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PWM_W, 8, PWM counter width; PWM period is 2^PWM_W cycles.
- TAIL_DUTY, 77, tail-lamp duty in counts (~30% at PWM_W=8).
- REV_DUTY, 179, reverse-lamp duty in counts (~70%).
- DARK_ON, 100, cds_val strictly below this counts as dark.
- DARK_OFF, 130, cds_val strictly above this counts as bright; SHALL be > DARK_ON.
- DWELL, 1000, consecutive cycles a dark/bright condition must hold before is_dark changes.
- BLINK_HALF, 25_000_000, cycles per indicator half-period.
- FADE_DIV, 16, cycles per headlight level step.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- sw_headlight, in, 1, manual headlight switch.
- sw_high_beam, in, 1, high-beam switch.
- sw_hazard, in, 1, hazard switch.
- cds_val, in, 8, light sensor value; high = bright.
- is_brake, in, 1, brake active.
- is_reverse, in, 1, reverse gear engaged.
- turn_left, in, 1, left indicator request (level).
- turn_right, in, 1, right indicator request (level).
- fc_red, fc_green, fc_blue, out, 4 each, full-colour LEDs; [0],[1] high beam, [2],[3] low beam; high = on.
- led_port, out, 8, [7:6] left indicator, [5],[2] outer tail, [4],[3] inner tail/reverse, [1:0] right indicator.
- head_level, out, PWM_W, current low-beam level.
- is_dark, out, 1, auto-light decision after hysteresis.

Function
REQ-003 pwm_cnt SHALL free-run from 0 to 2^PWM_W-1 and wrap to 0; duty d SHALL be lit iff pwm_cnt < d, so d=0 is never lit; 100% channels SHALL use constant 1.
REQ-004 A dwell counter SHALL count cycles in which is_dark=0 and cds_val<DARK_ON, or is_dark=1 and cds_val>DARK_OFF; when it reaches DWELL, is_dark SHALL toggle and the counter SHALL clear; any non-qualifying cycle SHALL clear the counter; values from DARK_ON to DARK_OFF inclusive SHALL hold is_dark.
REQ-005 head_req SHALL equal sw_headlight OR is_dark.
REQ-006 The fade FSM SHALL have states OFF (level 0), RISE (+1 every FADE_DIV cycles), ON (level 2^PWM_W-1) and FALL (-1 every FADE_DIV cycles).
REQ-007 Transitions: OFF->RISE on head_req=1; RISE->ON when the level reaches max; ON->FALL on head_req=0; FALL->OFF when the level reaches 0; RISE->FALL on head_req=0 and FALL->RISE on head_req=1, both continuing from the current level; the level SHALL saturate and never wrap.
REQ-008 Low beam (all colours, [2],[3]) SHALL be constant 1 in ON, 0 in OFF, and pwm_cnt<head_level otherwise.
REQ-009 High beam (all colours, [0],[1]) SHALL be 1 iff state=ON and sw_high_beam=1; it SHALL drop with ON->FALL.
REQ-010 left_act = turn_left OR sw_hazard; right_act = turn_right OR sw_hazard.
REQ-011 While either side is active, the blink counter SHALL run and blink phase SHALL toggle every BLINK_HALF cycles; with both inactive, the counter SHALL be 0 and phase 1, so a new request lights on the next cycle.
REQ-012 Indicator outputs SHALL be side_act AND phase; both sides SHALL share one phase.
REQ-013 Outer tail SHALL be 1 if is_brake, else (pwm_cnt<TAIL_DUTY) if state≠OFF, else 0.
REQ-014 Inner tail SHALL be (pwm_cnt<REV_DUTY) if is_reverse, otherwise it SHALL equal the outer tail; reverse SHALL override brake.
REQ-015 fc_*, led_port, head_level and is_dark SHALL be registered, giving 1-cycle latency from internal state/inputs to outputs.

Reset
REQ-016 While rst=0, all outputs, pwm_cnt, the dwell counter, the blink counter, head_level and is_dark SHALL be 0, the state SHALL be OFF, and phase SHALL be 1, asynchronously.
REQ-017 Reset asserted mid-fade or mid-blink SHALL discard progress; after release, operation SHALL restart from OFF with unlit indicators.

Structure
REQ-018 Package lamp_pkg SHALL hold the fade-state enum (OFF, RISE, ON, FALL) and the led_port/fc index constants.
REQ-019 The blink generator (counter, phase, clear-on-idle) SHALL be sub-module blink_gen; all other logic SHALL stay in lamp_controller.

Verification (PWM_W=4, DWELL=4, BLINK_HALF=8, FADE_DIV=2)
REQ-020 cds_val=50 for 3 cycles then 200 -> is_dark stays 0; cds_val=50 held -> is_dark=1 on the 5th cycle; then cds_val=115 for 100 cycles -> is_dark stays 1.
REQ-021 sw_headlight 0->1 -> head_level steps 0..15, one step per 2 cycles, state ON after 30 cycles; drop at level 6 -> FALL from 6 to 0, never wraps.
REQ-022 sw_hazard=1 -> led_port[7:6] and [1:0] both 11 one cycle later, toggling every 8 cycles; release -> 0 and phase restored.
REQ-023 state ON, is_reverse=1, is_brake=1 -> led_port[5],[2]=1 constantly; led_port[4],[3] high for 11 of every 16 cycles (REV_DUTY=11).
REQ-024 rst pulsed low during RISE at level 9 -> all outputs 0 immediately; after release with head_req=1, level restarts from 0.
